frame_flow_ctrl: RTL and testbench

FRAME_FLOW_CTRL -- requirements
Module: frame_flow_ctrl

---
 rtl/frame_flow_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_frame_flow_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_flow_ctrl.sv
// Frame-level flow controller: gates the upstream pixel stream into the pipeline, tracks input
// row/col and output beats, and signals frame completion. Optional DRAIN watchdog: FRAME_FLOW_TMO_EN.
module frame_flow_ctrl #(
  parameter int unsigned IMG_W   = 512,
  parameter int unsigned IMG_H   = 512,
  parameter int unsigned OUT_PIX = IMG_W * (IMG_H - 2),
  parameter int unsigned TMO_CYC = 65535
) (
  input  logic        axi_clk,
  input  logic        axi_rst,
  input  logic        i_start,
  input  logic        i_intr_clr,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        p_valid,
  input  logic        p_prog_full,
  input  logic        m_valid,
  input  logic        m_ready,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_intr,
  output logic        o_err,
  output logic [11:0] o_row,
  output logic [11:0] o_col
);

  localparam int unsigned OcntW = $clog2(OUT_PIX + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [11:0]        row_q, row_d;
  logic [11:0]        col_q, col_d;
  logic [OcntW-1:0]   ocnt_q, ocnt_d;
  logic               intr_q, intr_d;
  logic               busy_q;
  logic               done_q;

  logic in_run;
  logic in_active;
  logic accept;
  logic m_beat;
  logic col_last;
  logic row_last;
  logic cnt_full;
  logic tmo_hit;

  assign in_run    = (state_q == StRun);
  assign in_active = (state_q == StRun) || (state_q == StDrain);
  assign s_ready   = in_run && !p_prog_full;
  assign p_valid   = s_valid && s_ready;
  assign accept    = p_valid;
  assign m_beat    = m_valid && m_ready;
  assign col_last  = (col_q == 12'(IMG_W - 1));
  assign row_last  = (row_q == 12'(IMG_H - 1));
  assign cnt_full  = (ocnt_q == OcntW'(OUT_PIX));

`ifdef FRAME_FLOW_TMO_EN
  localparam int unsigned TmoW = $clog2(TMO_CYC + 1);

  logic [TmoW-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  // Watchdog only runs while draining; any observed output beat restarts it.
  always_comb begin
    wd_d = '0;
    if (state_q == StDrain && !m_beat) begin
      wd_d = wd_q + TmoW'(1);
    end
  end

  assign tmo_hit = (state_q == StDrain) && !m_beat && !cnt_full &&
                   (wd_q == TmoW'(TMO_CYC - 1));

  always_comb begin
    err_d = err_q;
    if (tmo_hit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge axi_clk or negedge axi_rst) begin
    if (!axi_rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign o_err = err_q;
`else
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign unused_tmo = ^TMO_CYC;
  assign o_err      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    ocnt_d  = ocnt_q;

    // Saturate so late beats after the frame is complete cannot wrap the count.
    if (m_beat && in_active && !cnt_full) begin
      ocnt_d = ocnt_q + OcntW'(1);
    end

    // The final pixel wraps col but leaves row parked on the last line.
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        if (!row_last) begin
          row_d = row_q + 12'd1;
        end
      end else begin
        col_d = col_q + 12'd1;
      end
    end

    case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (accept && row_last && col_last) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (cnt_full || tmo_hit) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        row_d   = '0;
        col_d   = '0;
        ocnt_d  = '0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Set is taken from the DONE cycle itself, so a clear in that same cycle loses.
  always_comb begin
    intr_d = intr_q;
    if (state_q == StDone) begin
      intr_d = 1'b1;
    end else if (i_intr_clr) begin
      intr_d = 1'b0;
    end
  end

  always_ff @(posedge axi_clk or negedge axi_rst) begin
    if (!axi_rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      ocnt_q  <= '0;
      intr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ocnt_q  <= ocnt_d;
      intr_q  <= intr_d;
      busy_q  <= (state_d == StRun) || (state_d == StDrain);
      done_q  <= (state_d == StDone);
    end
  end

  assign o_busy       = busy_q;
  assign o_frame_done = done_q;
  assign o_intr       = intr_q;
  assign o_row        = row_q;
  assign o_col        = col_q;

endmodule

// File: tb/tb_frame_flow_ctrl.sv
// Directed bench for frame_flow_ctrl on a 4x4 frame with 8 output pixels and a 10-cycle watchdog.
module tb_frame_flow_ctrl;

  logic        axi_clk = 1'b0;
  logic        axi_rst = 1'b0;
  logic        i_start = 1'b0;
  logic        i_intr_clr = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        p_valid;
  logic        p_prog_full = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_ready = 1'b0;
  logic        o_busy;
  logic        o_frame_done;
  logic        o_intr;
  logic        o_err;
  logic [11:0] o_row;
  logic [11:0] o_col;

  int checks = 0;
  int passes = 0;

  frame_flow_ctrl #(
    .IMG_W  (4),
    .IMG_H  (4),
    .OUT_PIX(8),
    .TMO_CYC(10)
  ) dut (
    .axi_clk     (axi_clk),
    .axi_rst     (axi_rst),
    .i_start     (i_start),
    .i_intr_clr  (i_intr_clr),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .p_valid     (p_valid),
    .p_prog_full (p_prog_full),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .o_busy      (o_busy),
    .o_frame_done(o_frame_done),
    .o_intr      (o_intr),
    .o_err       (o_err),
    .o_row       (o_row),
    .o_col       (o_col)
  );

  always #5 axi_clk = ~axi_clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

  task automatic step();
    @(posedge axi_clk);
    #2;
  endtask

  // Streams pixels until s_ready drops (DRAIN), with output beats on the first mbeats cycles.
  task automatic pump(input int mbeats, output int acc);
    int i;
    acc = 0;
    i = 0;
    s_valid = 1'b1;
    m_ready = 1'b1;
    m_valid = (mbeats > 0);
    #1;
    while (s_ready && i < 40) begin
      if (p_valid) acc++;
      step();
      i++;
      m_valid = (i < mbeats);
      #1;
    end
    s_valid = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic watch_done(input int n, output int pulses, output int first);
    pulses = 0;
    first = -1;
    for (int i = 0; i < n; i++) begin
      if (o_frame_done) begin
        pulses++;
        if (first < 0) first = i;
      end
      step();
    end
  endtask

  task automatic beats(input int n);
    m_valid = 1'b1;
    m_ready = 1'b1;
    repeat (n) step();
    m_valid = 1'b0;
  endtask

  task automatic clear_intr();
    i_intr_clr = 1'b1;
    step();
    i_intr_clr = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({s_ready, p_valid, o_busy, o_frame_done, o_intr, o_err, o_row, o_col} !== 30'd0)
      $display("FAIL reset_outputs: got %b want all zero",
               {s_ready, p_valid, o_busy, o_frame_done, o_intr, o_err, o_row, o_col});
    else passes++;
    repeat (2) step();
    axi_rst = 1'b1;
    step();
  endtask

  task automatic test_basic_frame();
    int acc, pulses, first;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    checks++;
    if (o_busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", o_busy);
    else passes++;
    s_valid = 1'b1;
    #1;
    checks++;
    if ({s_ready, p_valid} !== 2'b11) $display("FAIL basic_ready: got %b want 11", {s_ready, p_valid});
    else passes++;
    repeat (5) step();
    checks++;
    if ({o_row, o_col} !== {12'd1, 12'd1})
      $display("FAIL basic_rowcol: got row %0d col %0d want row 1 col 1", o_row, o_col);
    else passes++;
    pump(0, acc);
    checks++;
    if (acc !== 11) $display("FAIL basic_accepts: got %0d want 11", acc);
    else passes++;
    checks++;
    if ({s_ready, o_busy} !== 2'b01) $display("FAIL basic_drain: got %b want 01", {s_ready, o_busy});
    else passes++;
    beats(8);
    watch_done(6, pulses, first);
    checks++;
    if (pulses !== 1 || first !== 1)
      $display("FAIL basic_done: got pulses %0d at %0d want 1 at 1", pulses, first);
    else passes++;
    checks++;
    if ({o_intr, o_busy, o_err, o_row, o_col} !== {1'b1, 1'b0, 1'b0, 24'd0})
      $display("FAIL basic_after: got intr %b busy %b err %b row %0d col %0d want 1 0 0 0 0",
               o_intr, o_busy, o_err, o_row, o_col);
    else passes++;
    clear_intr();
    checks++;
    if (o_intr !== 1'b0) $display("FAIL basic_intr_clr: got %b want 0", o_intr);
    else passes++;
  endtask

  task automatic test_backpressure();
    int acc, pulses, first;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    s_valid = 1'b1;
    step();
    step();
    checks++;
    if (o_col !== 12'd2) $display("FAIL bp_pre_col: got %0d want 2", o_col);
    else passes++;
    p_prog_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if ({s_ready, p_valid, o_col} !== {2'b00, 12'd2})
        $display("FAIL bp_stall: got ready %b valid %b col %0d want 0 0 2", s_ready, p_valid, o_col);
      else passes++;
      step();
    end
    p_prog_full = 1'b0;
    pump(0, acc);
    checks++;
    if (acc !== 14) $display("FAIL bp_accepts: got %0d want 14", acc);
    else passes++;
    beats(8);
    watch_done(4, pulses, first);
    checks++;
    if (pulses !== 1 || first !== 1)
      $display("FAIL bp_done: got pulses %0d at %0d want 1 at 1", pulses, first);
    else passes++;
    clear_intr();
  endtask

  task automatic test_ignore();
    int acc, pulses, first;
    beats(20);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    s_valid = 1'b1;
    step();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    step();
    checks++;
    if ({o_busy, o_row, o_col} !== {1'b1, 12'd0, 12'd3})
      $display("FAIL ign_restart: got busy %b row %0d col %0d want 1 0 3", o_busy, o_row, o_col);
    else passes++;
    pump(7, acc);
    checks++;
    if (acc !== 13) $display("FAIL ign_accepts: got %0d want 13", acc);
    else passes++;
    repeat (3) step();
    checks++;
    if ({o_busy, o_frame_done} !== 2'b10)
      $display("FAIL ign_drain_wait: got %b want 10", {o_busy, o_frame_done});
    else passes++;
    beats(1);
    watch_done(4, pulses, first);
    checks++;
    if (pulses !== 1 || first !== 1)
      $display("FAIL ign_done: got pulses %0d at %0d want 1 at 1", pulses, first);
    else passes++;
    clear_intr();
  endtask

  task automatic test_back_to_back();
    int acc, pulses, first;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    pump(16, acc);
    checks++;
    if ({acc == 16, o_busy, o_frame_done} !== 3'b110)
      $display("FAIL b2b_run_full: got acc %0d busy %b done %b want 16 1 0", acc, o_busy, o_frame_done);
    else passes++;
    step();
    checks++;
    if (o_frame_done !== 1'b1) $display("FAIL b2b_done_pulse: got %b want 1", o_frame_done);
    else passes++;
    i_start = 1'b1;
    i_intr_clr = 1'b1;
    step();
    checks++;
    if ({o_busy, o_frame_done, o_intr} !== 3'b001)
      $display("FAIL b2b_done_cycle: got busy %b done %b intr %b want 0 0 1", o_busy, o_frame_done, o_intr);
    else passes++;
    step();
    i_start = 1'b0;
    i_intr_clr = 1'b0;
    checks++;
    if ({o_busy, o_intr} !== 2'b10)
      $display("FAIL b2b_restart: got busy %b intr %b want 1 0", o_busy, o_intr);
    else passes++;
    pump(8, acc);
    checks++;
    if (acc !== 16) $display("FAIL b2b_accepts: got %0d want 16", acc);
    else passes++;
    watch_done(4, pulses, first);
    checks++;
    if (pulses !== 1 || first !== 1)
      $display("FAIL b2b_done2: got pulses %0d at %0d want 1 at 1", pulses, first);
    else passes++;
    clear_intr();
  endtask

`ifdef FRAME_FLOW_TMO_EN
  task automatic test_timeout();
    int acc, pulses, first;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    pump(5, acc);
    step();
    step();
    beats(1);
    // Index 0 is the first cycle after the last beat; 10 beat-free DRAIN cycles then DONE.
    watch_done(15, pulses, first);
    checks++;
    if (pulses !== 1 || first !== 10)
      $display("FAIL tmo_done: got pulses %0d at %0d want 1 at 10", pulses, first);
    else passes++;
    checks++;
    if ({o_err, o_intr, o_busy} !== 3'b110)
      $display("FAIL tmo_flags: got err %b intr %b busy %b want 1 1 0", o_err, o_intr, o_busy);
    else passes++;
    clear_intr();
  endtask
`endif

  task automatic test_reset_mid();
    int pulses, first, guard;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    s_valid = 1'b1;
    guard = 0;
    while (o_row != 12'd2 && guard < 20) begin
      step();
      guard++;
    end
    #1;
    axi_rst = 1'b0;
    #1;
    checks++;
    if ({s_ready, p_valid, o_busy, o_frame_done, o_intr, o_err, o_row, o_col} !== 30'd0)
      $display("FAIL rst_mid_outputs: got %b want all zero",
               {s_ready, p_valid, o_busy, o_frame_done, o_intr, o_err, o_row, o_col});
    else passes++;
    s_valid = 1'b0;
    step();
    step();
    axi_rst = 1'b1;
    watch_done(4, pulses, first);
    checks++;
    if (pulses !== 0 || o_busy !== 1'b0)
      $display("FAIL rst_mid_nodone: got pulses %0d busy %b want 0 0", pulses, o_busy);
    else passes++;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    checks++;
    if ({o_busy, o_row, o_col} !== {1'b1, 24'd0})
      $display("FAIL rst_mid_restart: got busy %b row %0d col %0d want 1 0 0", o_busy, o_row, o_col);
    else passes++;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    checks++;
    if (o_col !== 12'd1) $display("FAIL rst_mid_col: got %0d want 1", o_col);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_ignore();
    test_back_to_back();
`ifdef FRAME_FLOW_TMO_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
